// File: rtl/imem_pkg.sv
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants and port-owner type for the instruction
//               memory fetch path.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package imem_pkg;
  localparam int          IMEM_WORDS = 64;
  localparam int          INSTR_W    = 32;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_DBG = 1'b1
  } imem_owner_t;
endpackage

`default_nettype wire

// File: rtl/imem_dbg_arb.sv
// ============================================================================
// Module      : imem_dbg_arb
// Description : Debug-port arbiter with bounded starvation and a registered
//               debug read response.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_dbg_arb
  import imem_pkg::*;
#(
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               dbg_req,
  input  logic [INSTR_W-1:0] imem_instr,
  output imem_owner_t        owner,
  output logic [INSTR_W-1:0] dbg_rdata,
  output logic               dbg_rvalid
);

  localparam logic [3:0] c_max_wait = 4'(DBG_MAX_WAIT);

  logic [3:0]         r_wait_cnt;
  logic [INSTR_W-1:0] r_rdata;
  logic               r_rvalid;
  logic               w_gnt;

  // A stalled IF stage cannot use the port, so debug takes it for free.
  assign w_gnt = dbg_req && (stall || (r_wait_cnt == c_max_wait));
  assign owner = w_gnt ? OWN_DBG : OWN_IF;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 4'd0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (!dbg_req || w_gnt) begin
        r_wait_cnt <= 4'd0;
      end else if (r_wait_cnt != c_max_wait) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_rdata <= imem_instr;
      end
    end
  end

  assign dbg_rdata  = r_rdata;
  assign dbg_rvalid = r_rvalid;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Program counter and instruction-memory port sharing between
//               IF and debug. Debug arbitration exists only when the macro
//               IMEM_FETCH_DBG_EN is defined; otherwise IF always owns the port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DBG_MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [31:0]        br_target,
  output logic [31:0]        if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  input  logic               dbg_req,
  input  logic [31:0]        dbg_addr,
  output logic               dbg_gnt,
  output logic [INSTR_W-1:0] dbg_rdata,
  output logic               dbg_rvalid,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_instr
);

  localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc;
  imem_owner_t w_owner;
  logic        w_unused;

`ifdef IMEM_FETCH_DBG_EN
  imem_dbg_arb #(
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_dbg_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .dbg_req    (dbg_req),
    .imem_instr (imem_instr),
    .owner      (w_owner),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid)
  );

  assign w_unused = ^{dbg_addr[1:0], br_target[1:0]};
`else
  assign w_owner    = OWN_IF;
  assign dbg_rdata  = '0;
  assign dbg_rvalid = 1'b0;

  assign w_unused = ^{dbg_req, dbg_addr, br_target[1:0], DBG_MAX_WAIT[0]};
`endif

  assign dbg_gnt   = (w_owner == OWN_DBG);
  assign imem_addr = dbg_gnt ? {dbg_addr[31:2], 2'b00} : r_pc;
  assign if_valid  = !dbg_gnt && !stall;
  assign if_instr  = dbg_gnt ? '0 : imem_instr;
  assign if_pc     = r_pc;

  // A redirect wins even during a debug slot; otherwise a debug slot is a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= c_reset_pc;
    end else if (br_taken) begin
      r_pc <= {br_target[31:2], 2'b00};
    end else if (!dbg_gnt && !stall) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

endmodule

`default_nettype wire
